// File: rtl/peridot_cam_pkg.sv
// Shared definitions for the camera frame-capture sequencer.
//   state_e         : sequencer state encoding
//   BURST_BYTES     : bytes moved per master chunk
//   ADDR_ALIGN_MASK : clears the chunk-offset bits of a buffer base
//   align_addr()    : applies ADDR_ALIGN_MASK
package peridot_cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_KICK    = 3'd2,
    ST_WAITLOW = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam int unsigned BURST_BYTES     = 64;
  localparam logic [31:0] ADDR_ALIGN_MASK = ~(32'(BURST_BYTES) - 32'd1);

  function automatic logic [31:0] align_addr(input logic [31:0] a);
    return a & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/peridot_cam_framectl.sv
// Frame-capture sequencer between the CSR slave and the burst write master.
// Arms on cmd_start, waits for VSYNC, programs and kicks the master, waits
// for its done, then updates buffer select, frame counter and interrupt.
// Ports:
//   csi_global_clk / csi_global_reset : clock, sync active-high reset
//   cmd_start / cmd_stop              : arm / stop-after-frame pulses
//   cfg_*                             : mode, buffer bases, chunk count
//   cam_vsync_pulse                   : frame start pulse
//   avm_address_top/transcycle_num/start, avm_done : master handshake
//   fifo_clear                        : pixel FIFO flush
//   stat_*, overrun_clr, irq_frame    : status and interrupt
module peridot_cam_framectl
  import peridot_cam_pkg::*;
#(
  parameter int FRAMECOUNT_W = 16,
  parameter int KICK_HOLD    = 1
) (
  input  logic                    csi_global_clk,
  input  logic                    csi_global_reset,
  input  logic                    cmd_start,
  input  logic                    cmd_stop,
  input  logic                    cfg_continuous,
  input  logic                    cfg_doublebuf,
  input  logic [31:0]             cfg_addr_a,
  input  logic [31:0]             cfg_addr_b,
  input  logic [15:0]             cfg_transcycle_num,
  input  logic                    cam_vsync_pulse,
  output logic [31:0]             avm_address_top,
  output logic [15:0]             avm_transcycle_num,
  output logic                    avm_start,
  input  logic                    avm_done,
  output logic                    fifo_clear,
  output logic                    stat_busy,
  output logic                    stat_bufsel,
  output logic [FRAMECOUNT_W-1:0] stat_framecount,
  output logic                    stat_overrun,
  input  logic                    overrun_clr,
  output logic                    irq_frame
);

  localparam logic [1:0] KICK_LAST = 2'(KICK_HOLD - 1);

  state_e                  state_q, state_d;
  logic [1:0]              kick_cnt_q, kick_cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [15:0]             tc_q, tc_d;
  logic                    start_q, start_d;
  logic                    fclr_q, fclr_d;
  logic                    bufsel_q, bufsel_d;
  logic                    next_buf_q, next_buf_d;
  logic [FRAMECOUNT_W-1:0] fc_q, fc_d;
  logic                    ovr_q, ovr_d;
  logic                    irq_q, irq_d;
  logic                    stop_pend_q, stop_pend_d;
  logic                    in_frame;

  // States in which the master owns the frame and cannot be aborted.
  assign in_frame = (state_q == ST_KICK) || (state_q == ST_WAITLOW) ||
                    (state_q == ST_CAPTURE);

  always_comb begin
    state_d     = state_q;
    kick_cnt_d  = '0;
    addr_d      = addr_q;
    tc_d        = tc_q;
    start_d     = start_q;
    bufsel_d    = bufsel_q;
    next_buf_d  = next_buf_q;
    fc_d        = fc_q;
    stop_pend_d = stop_pend_q;
    ovr_d       = ovr_q;

    case (state_q)
      ST_IDLE: begin
        // A zero count would make the master run 65536 chunks.
        if (cmd_start && !cmd_stop && (cfg_transcycle_num != 16'd0)) begin
          state_d    = ST_ARMED;
          next_buf_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cam_vsync_pulse) begin
          addr_d  = align_addr(next_buf_q ? cfg_addr_b : cfg_addr_a);
          tc_d    = cfg_transcycle_num;
          start_d = 1'b1;
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        if (kick_cnt_q == KICK_LAST) begin
          start_d = 1'b0;
          state_d = ST_WAITLOW;
        end else begin
          kick_cnt_d = kick_cnt_q + 2'd1;
        end
      end
      // Wait for done to fall first so a stale idle level is not taken
      // as completion of the frame just kicked.
      ST_WAITLOW: if (!avm_done) state_d = ST_CAPTURE;
      ST_CAPTURE: if (avm_done)  state_d = ST_FINISH;
      ST_FINISH: begin
        bufsel_d    = next_buf_q;
        fc_d        = fc_q + 1'b1;
        next_buf_d  = cfg_doublebuf ? ~next_buf_q : 1'b0;
        state_d     = (cfg_continuous && !stop_pend_q && !cmd_stop) ? ST_ARMED : ST_IDLE;
        stop_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_frame && cmd_stop) stop_pend_d = 1'b1;

    // Set has priority over clear.
    if (in_frame && cam_vsync_pulse) ovr_d = 1'b1;
    else if (overrun_clr)            ovr_d = 1'b0;

    fclr_d = (state_d == ST_IDLE) || (state_d == ST_ARMED);
    irq_d  = (state_d == ST_FINISH);
  end

  always_ff @(posedge csi_global_clk) begin
    if (csi_global_reset) begin
      state_q     <= ST_IDLE;
      kick_cnt_q  <= '0;
      addr_q      <= '0;
      tc_q        <= '0;
      start_q     <= 1'b0;
      fclr_q      <= 1'b1;
      bufsel_q    <= 1'b0;
      next_buf_q  <= 1'b0;
      fc_q        <= '0;
      ovr_q       <= 1'b0;
      irq_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kick_cnt_q  <= kick_cnt_d;
      addr_q      <= addr_d;
      tc_q        <= tc_d;
      start_q     <= start_d;
      fclr_q      <= fclr_d;
      bufsel_q    <= bufsel_d;
      next_buf_q  <= next_buf_d;
      fc_q        <= fc_d;
      ovr_q       <= ovr_d;
      irq_q       <= irq_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign avm_address_top    = addr_q;
  assign avm_transcycle_num = tc_q;
  assign avm_start          = start_q;
  assign fifo_clear         = fclr_q;
  assign stat_busy          = (state_q != ST_IDLE);
  assign stat_bufsel        = bufsel_q;
  assign stat_framecount    = fc_q;
  assign stat_overrun       = ovr_q;
  assign irq_frame          = irq_q;

endmodule
